// File: rtl/alu_arbiter.sv
// Two-requester front end for a registered ALU: arbitrates, issues one operation
// at a time, captures the ALU result and holds the response until accepted.
module alu_arbiter #(
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [3:0] req_a0,
   input  logic [3:0] req_b0,
   input  logic [3:0] req_a1,
   input  logic [3:0] req_b1,
   input  logic [2:0] req_op0,
   input  logic [2:0] req_op1,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_opn,
   output logic       alu_rst,
   input  logic [3:0] alu_out0,
   input  logic [3:0] alu_out1,
   input  logic [3:0] alu_status,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic       resp_id,
   output logic [3:0] resp_lo,
   output logic [3:0] resp_hi,
   output logic       resp_flag,
   output logic       resp_err
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_LT  = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

   state_t     state, state_nxt;
   logic       rr_ptr;   // 0 favours requester 0 on contention
   logic [3:0] a_q, b_q;
   logic [2:0] op_q;
   logic [1:0] gnt;
   logic       gnt_id;
   logic [3:0] gnt_a, gnt_b;
   logic [2:0] gnt_op;
   logic       take;
   logic       status_unused;

   assign status_unused = ^{alu_status[3], alu_status[0]};

   always_comb begin
      gnt = 2'b00;
      if (req_valid == 2'b01)      gnt = 2'b01;
      else if (req_valid == 2'b10) gnt = 2'b10;
      else if (req_valid == 2'b11) gnt = (FIXED_PRI || !rr_ptr) ? 2'b01 : 2'b10;
   end

   assign gnt_id = gnt[1];
   assign gnt_a  = gnt_id ? req_a1  : req_a0;
   assign gnt_b  = gnt_id ? req_b1  : req_b0;
   assign gnt_op = gnt_id ? req_op1 : req_op0;
   assign take   = (state == IDLE) && (req_valid != 2'b00);

   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      case (state)
         IDLE: if (take) begin
            req_ready = gnt;
            state_nxt = (gnt_op == OP_ILL) ? RESP : EXEC;
         end
         EXEC: state_nxt = CAPT;
         CAPT: state_nxt = RESP;
         RESP: if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         resp_id   <= 1'b0;
         resp_lo   <= '0;
         resp_hi   <= '0;
         resp_flag <= 1'b0;
         resp_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take) begin
            resp_id <= gnt_id;
            rr_ptr  <= ~gnt_id;
            a_q     <= gnt_a;
            b_q     <= gnt_b;
            // Illegal opcodes bypass the ALU, so its opcode register is left alone.
            if (gnt_op == OP_ILL) begin
               resp_err  <= 1'b1;
               resp_lo   <= '0;
               resp_hi   <= '0;
               resp_flag <= 1'b0;
            end else begin
               op_q <= gnt_op;
            end
         end
         if (state == CAPT) begin
            resp_lo   <= alu_out0;
            resp_hi   <= (op_q == OP_MUL) ? alu_out1 : 4'd0;
            resp_flag <= (op_q == OP_ADD || op_q == OP_SUB) ? alu_status[1] :
                         (op_q == OP_LT) ? alu_status[2] : 1'b0;
            resp_err  <= 1'b0;
         end
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_opn    = op_q;
   assign alu_rst    = ~rst;
   assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter: round-robin and fixed-priority instances,
// each paired with a behavioural registered ALU.
module tb_alu_arbiter;

   typedef struct packed {
      logic       id;
      logic [3:0] lo;
      logic [3:0] hi;
      logic       flag;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid, fp_req_valid;
   logic [3:0] req_a0, req_b0, req_a1, req_b1;
   logic [2:0] req_op0, req_op1;
   logic       resp_ready;
   logic       fp_resp_ready;

   logic [1:0] req_ready, fp_req_ready;
   logic [3:0] alu_a, alu_b, fp_alu_a, fp_alu_b;
   logic [2:0] alu_opn, fp_alu_opn;
   logic       alu_rst, fp_alu_rst;
   logic [3:0] alu_out0, alu_out1, alu_status;
   logic [3:0] fp_alu_out0, fp_alu_out1, fp_alu_status;
   logic       resp_valid, resp_id, resp_flag, resp_err;
   logic [3:0] resp_lo, resp_hi;
   logic       fp_resp_valid, fp_resp_id, fp_resp_flag, fp_resp_err;
   logic [3:0] fp_resp_lo, fp_resp_hi;

   exp_t q[$];
   exp_t fp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.FIXED_PRI(1'b0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_op0(req_op0), .req_op1(req_op1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opn(alu_opn), .alu_rst(alu_rst),
      .alu_out0(alu_out0), .alu_out1(alu_out1), .alu_status(alu_status),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_lo(resp_lo), .resp_hi(resp_hi), .resp_flag(resp_flag), .resp_err(resp_err)
   );

   alu_arbiter #(.FIXED_PRI(1'b1)) dut_fp (
      .clk(clk), .rst(rst), .req_valid(fp_req_valid), .req_ready(fp_req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_op0(req_op0), .req_op1(req_op1),
      .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_opn(fp_alu_opn), .alu_rst(fp_alu_rst),
      .alu_out0(fp_alu_out0), .alu_out1(fp_alu_out1), .alu_status(fp_alu_status),
      .resp_valid(fp_resp_valid), .resp_ready(fp_resp_ready), .resp_id(fp_resp_id),
      .resp_lo(fp_resp_lo), .resp_hi(fp_resp_hi), .resp_flag(fp_resp_flag), .resp_err(fp_resp_err)
   );

   // Registered ALU: returns {status, out1, out0}.
   function automatic logic [11:0] alu_calc(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] op);
      logic [3:0] o0, o1, st;
      logic [4:0] s;
      logic [7:0] p;
      o0 = 4'd0; o1 = 4'd0; st = 4'd0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; o0 = s[3:0]; st[1] = s[4]; end
         3'd1: begin o0 = a - b; st[1] = (a < b); end
         3'd2: begin p = a * b; o0 = p[3:0]; o1 = p[7:4]; end
         3'd3: o0 = a & b;
         3'd4: o0 = a | b;
         3'd5: o0 = a ^ b;
         3'd6: st[2] = (a < b);
         default: ;
      endcase
      return {st, o1, o0};
   endfunction

   always @(posedge clk) begin
      if (alu_rst) {alu_status, alu_out1, alu_out0} <= '0;
      else         {alu_status, alu_out1, alu_out0} <= alu_calc(alu_a, alu_b, alu_opn);
      if (fp_alu_rst) {fp_alu_status, fp_alu_out1, fp_alu_out0} <= '0;
      else            {fp_alu_status, fp_alu_out1, fp_alu_out0} <= alu_calc(fp_alu_a, fp_alu_b, fp_alu_opn);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitors: pop and compare on every accepted response.
   always @(negedge clk) begin
      if (rst === 1'b1 && resp_valid && resp_ready) begin
         if (q.size() == 0) chk("resp_unexpected", 1, 0);
         else chk("resp", {resp_id, resp_lo, resp_hi, resp_flag, resp_err}, q.pop_front());
      end
      if (rst === 1'b1 && fp_resp_valid && fp_resp_ready) begin
         if (fp_q.size() == 0) chk("fp_resp_unexpected", 1, 0);
         else chk("fp_resp", {fp_resp_id, fp_resp_lo, fp_resp_hi, fp_resp_flag, fp_resp_err},
                  fp_q.pop_front());
      end
   end

   task automatic wait_gnt(input bit fp, output logic [1:0] g, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         g = fp ? fp_req_ready : req_ready;
      end while (g == 2'b00 && n < 20);
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 20);
   endtask

   task automatic drain();
      int k = 0;
      while ((q.size() != 0 || fp_q.size() != 0) && k < 20) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] g;
      int         n;
      rst = 1'b0; req_valid = 2'b00; fp_req_valid = 2'b00;
      req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0; req_op0 = 0; req_op1 = 0;
      resp_ready = 1'b0; fp_resp_ready = 1'b1;

      // Reset state
      step(); step();
      @(negedge clk);
      chk("rst_outs", {resp_valid, resp_id, resp_lo, resp_hi, resp_flag, resp_err,
                       req_ready, alu_a, alu_b, alu_opn}, 0);
      chk("rst_alu_rst", alu_rst, 1);
      step(); rst = 1'b1;
      @(negedge clk);
      chk("alu_rst_rel", alu_rst, 0);

      // Single ADD 9+8
      step(); req_valid = 2'b01; req_a0 = 9; req_b0 = 8; req_op0 = 3'd0; resp_ready = 1'b1;
      wait_gnt(0, g, n);
      chk("add_gnt", g, 2'b01);
      q.push_back('{id:1'b0, lo:4'd1, hi:4'd0, flag:1'b1, err:1'b0});
      step(); req_valid = 2'b00;
      wait_resp(n);
      chk("add_latency", n, 3);

      // Reset to bring the pointer back to requester 0, then contend
      step(); rst = 1'b0;
      step(); rst = 1'b1;
      req_valid = 2'b11; req_a0 = 15; req_b0 = 15; req_op0 = 3'd2;
      req_a1 = 3; req_b1 = 5; req_op1 = 3'd6;
      for (int i = 0; i < 3; i++) begin
         wait_gnt(0, g, n);
         chk("rr_gnt", g, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (i > 0) chk("rr_spacing", n, 4);
         if (i % 2 == 0) q.push_back('{id:1'b0, lo:4'd1, hi:4'd14, flag:1'b0, err:1'b0});
         else            q.push_back('{id:1'b1, lo:4'd0, hi:4'd0,  flag:1'b1, err:1'b0});
      end
      step(); req_valid = 2'b00;
      drain();

      // Backpressure on SUB 2-5 with requester 1 waiting
      step(); req_valid = 2'b01; req_a0 = 2; req_b0 = 5; req_op0 = 3'd1; resp_ready = 1'b0;
      wait_gnt(0, g, n);
      chk("sub_gnt", g, 2'b01);
      q.push_back('{id:1'b0, lo:4'd13, hi:4'd0, flag:1'b1, err:1'b0});
      step(); req_valid = 2'b10; req_a1 = 3; req_b1 = 5; req_op1 = 3'd5;
      wait_resp(n);
      chk("sub_latency", n, 3);
      for (int k = 0; k < 5; k++) begin
         chk("bp_hold", {resp_valid, resp_lo, resp_flag, req_ready}, {1'b1, 4'd13, 1'b1, 2'b00});
         @(negedge clk);
      end
      step(); resp_ready = 1'b1;
      @(negedge clk);
      chk("hs_no_gnt", req_ready, 2'b00);
      wait_gnt(0, g, n);
      chk("xor_gnt", g, 2'b10);
      chk("xor_gnt_delay", n, 1);
      q.push_back('{id:1'b1, lo:4'd6, hi:4'd0, flag:1'b0, err:1'b0});
      step(); req_valid = 2'b00;
      drain();

      // Illegal opcode from requester 1
      step(); req_valid = 2'b10; req_a1 = 7; req_b1 = 7; req_op1 = 3'd7;
      wait_gnt(0, g, n);
      chk("ill_gnt", g, 2'b10);
      q.push_back('{id:1'b1, lo:4'd0, hi:4'd0, flag:1'b0, err:1'b1});
      step(); req_valid = 2'b00;
      wait_resp(n);
      chk("ill_latency", n, 1);
      chk("ill_opn_kept", alu_opn, 3'd5);
      drain();

      // Reset during EXEC abandons the operation
      step(); req_valid = 2'b01; req_a0 = 9; req_b0 = 8; req_op0 = 3'd0;
      req_a1 = 1; req_b1 = 1; req_op1 = 3'd0;
      wait_gnt(0, g, n);
      chk("mid_gnt", g, 2'b01);
      step(); rst = 1'b0; req_valid = 2'b11;
      @(negedge clk);
      chk("mid_alu_rst", alu_rst, 1);
      chk("mid_no_gnt", req_ready, 2'b00);
      step(); rst = 1'b1;
      @(negedge clk);
      chk("post_rst_gnt", req_ready, 2'b01);
      chk("post_rst_valid", resp_valid, 0);
      q.push_back('{id:1'b0, lo:4'd1, hi:4'd0, flag:1'b1, err:1'b0});
      step(); req_valid = 2'b00;
      wait_resp(n);
      chk("post_rst_latency", n, 3);
      drain();

      // Fixed priority instance
      step(); fp_req_valid = 2'b11; req_a0 = 15; req_b0 = 15; req_op0 = 3'd2;
      req_a1 = 3; req_b1 = 5; req_op1 = 3'd6;
      for (int i = 0; i < 3; i++) begin
         wait_gnt(1, g, n);
         chk("fp_gnt", g, 2'b01);
         fp_q.push_back('{id:1'b0, lo:4'd1, hi:4'd14, flag:1'b0, err:1'b0});
      end
      step(); fp_req_valid = 2'b00;
      drain();

      chk("q_empty", q.size(), 0);
      chk("fp_q_empty", fp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRI, default 0, meaning 0 = round-robin arbitration and 1 = requester 0 always wins.
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk, in, 1, the single clock; all state changes on its rising edge.
- rst, in, 1, synchronous active-low reset.
- req_valid, in, 2, one request-valid bit per requester (bit k = requester k).
- req_ready, out, 2, one-hot accept strobe per requester.
- req_a0, req_b0, in, 4 each, operands from requester 0.
- req_a1, req_b1, in, 4 each, operands from requester 1.
- req_op0, req_op1, in, 3 each, opcodes: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110 LT.
- alu_a, alu_b, out, 4 each, ALU operands.
- alu_opn, out, 3, ALU opcode.
- alu_rst, out, 1, active-high ALU reset.
- alu_out0, alu_out1, in, 4 each, registered ALU results.
- alu_status, in, 4, ALU status; bit1 = carry/borrow, bit2 = less-than.
- resp_valid, out, 1, response valid.
- resp_ready, in, 1, response accepted.
- resp_id, out, 1, index of the requester being answered.
- resp_lo, resp_hi, out, 4 each, result nibbles.
- resp_flag, out, 1, carry/borrow or less-than result.
- resp_err, out, 1, illegal-opcode indication.

Function
REQ-003 The FSM SHALL have exactly four states, IDLE, EXEC, CAPT and RESP, with one operation in flight at a time.
REQ-004 In IDLE, with any req_valid set, the block SHALL pick a winner, assert only that requester's req_ready bit for that cycle (combinational), latch its operands and opcode, record resp_id, and move to EXEC.
REQ-005 req_ready SHALL be 0 in every state other than IDLE and whenever req_valid is 0.
REQ-006 Round-robin (FIXED_PRI=0): when both requesters are valid, the block SHALL grant the requester not granted last; a lone valid requester SHALL always be granted; after reset the pointer SHALL favour requester 0.
REQ-007 alu_a, alu_b and alu_opn SHALL be driven from the latched registers at all times, so they are stable throughout EXEC.
REQ-008 EXEC SHALL last one cycle, during which the ALU registers its result; the next state SHALL be CAPT.
REQ-009 In CAPT the block SHALL register the following and then move to RESP:
- resp_lo = alu_out0.
- resp_hi = alu_out1 for MUL, otherwise 0.
- resp_flag = alu_status[1] for ADD/SUB, alu_status[2] for LT, otherwise 0.
REQ-010 In RESP, resp_valid SHALL be 1 and all resp_* outputs SHALL hold stable until resp_ready is 1; on that cycle the block SHALL return to IDLE.
REQ-011 A new grant SHALL NOT occur in the same cycle as the resp_ready handshake; minimum spacing between grants is therefore 4 cycles.
REQ-012 Latency SHALL be: grant in cycle T, resp_valid first high in cycle T+3.
REQ-013 For opcode 111, the block SHALL grant normally and go straight from IDLE to RESP with resp_err=1 and resp_lo=resp_hi=resp_flag=0; the ALU opcode register SHALL keep its previous value.
REQ-014 resp_err SHALL be 0 for every legal opcode.
REQ-015 A requester dropping req_valid before it is granted SHALL NOT be granted; no request is queued inside the block.
REQ-016 resp_id SHALL identify the requester whose grant produced the current response.

Reset
REQ-017 When rst=0 at a clock edge, the block SHALL enter IDLE and clear the following to 0: resp_valid, resp_id, resp_lo, resp_hi, resp_flag, resp_err, the latched operands/opcode (so alu_a=alu_b=0, alu_opn=000), and the round-robin pointer (favours requester 0).
REQ-018 alu_rst SHALL equal the inverse of rst, so the ALU resets in the same cycles as this block.
REQ-019 Reset asserted in any state, including mid-operation, SHALL abandon the operation with no response; the first grant after reset follows REQ-006.

Verification
REQ-020 Single ADD: requester 0 valid with a=9, b=8, op=000, then resp_ready=1 → resp_valid at T+3 with resp_id=0, resp_lo=1, resp_hi=0, resp_flag=1, resp_err=0.
REQ-021 Contention: both valid continuously, requester 0 MUL a=15, b=15 and requester 1 LT a=3, b=5 → grants alternate 0,1,0; MUL returns resp_lo=1, resp_hi=14; LT returns resp_flag=1, resp_lo=0.
REQ-022 Backpressure: hold resp_ready=0 for 5 cycles after a SUB with a=2, b=5 → resp_valid and resp_lo=13, resp_flag=1 held stable, req_ready stays 0, no new grant.
REQ-023 Illegal opcode: requester 1 op=111 → resp_valid at T+1 with resp_err=1, resp_lo=0, resp_id=1.
REQ-024 Reset mid-EXEC: rst=0 for one cycle → alu_rst=1 that cycle, no response issued; with both requesters valid, the next grant goes to requester 0.
REQ-025 FIXED_PRI=1: both requesters valid for 3 operations → every grant goes to requester 0.
